// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch/bus-busy request bundle and the per-stage control responses of pipeline_ctrl.
// The controller connects through the slave modport. The hazard detector and pipeline side connects through the master modport.
interface pipeline_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [1:0]            hazard_i;
  logic                  branch_taken_i;
  logic [ADDR_WIDTH-1:0] branch_target_i;
  logic                  if_busy_i;
  logic                  if_ack_i;
  logic                  mem_busy_i;
  logic                  pc_we_o;
  logic                  pc_redirect_o;
  logic [ADDR_WIDTH-1:0] pc_target_o;
  logic                  ifid_stall_o;
  logic                  idex_stall_o;
  logic                  exmem_stall_o;
  logic                  memwb_stall_o;
  logic                  ifid_flush_o;
  logic                  idex_flush_o;
  logic                  exmem_flush_o;
  logic                  memwb_flush_o;
  logic                  drop_fetch_o;
  logic [31:0]           stall_cycles_o;
  logic [31:0]           flush_events_o;

  modport master (
    output hazard_i, branch_taken_i, branch_target_i, if_busy_i, if_ack_i, mem_busy_i,
    input  pc_we_o, pc_redirect_o, pc_target_o,
    input  ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o,
    input  ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
    input  drop_fetch_o, stall_cycles_o, flush_events_o
  );

  modport slave (
    input  hazard_i, branch_taken_i, branch_target_i, if_busy_i, if_ack_i, mem_busy_i,
    output pc_we_o, pc_redirect_o, pc_target_o,
    output ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o,
    output ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
    output drop_fetch_o, stall_cycles_o, flush_events_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline stall/flush/redirect controller with a pending-redirect hold while a fetch is in flight.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(32'h8000_0000)
) (
  input logic           clk_i,
  input logic           rst_ni,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic {RUN, REDIR_WAIT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] target_q;
  logic                  latch_target;

  logic [1:0] hazard;
  logic       branch_req, if_busy, if_ack, mem_busy, fetch_open;
  logic       pc_we, redirect, drop;
  // Stage order in the vectors: [0]=IF/ID, [1]=ID/EX, [2]=EX/MEM, [3]=MEM/WB
  logic [3:0] stall, flush;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RUN;
      target_q <= PC_ADDR;
    end else begin
      state_q <= state_d;
      if (latch_target) target_q <= bus.branch_target_i;
    end
  end

  // Inputs are masked while in reset so the outputs settle to the idle RUN response.
  always_comb begin
    hazard       = rst_ni ? bus.hazard_i : 2'b00;
    branch_req   = rst_ni & (bus.branch_taken_i | hazard[1]);
    if_busy      = rst_ni & bus.if_busy_i;
    if_ack       = rst_ni & bus.if_ack_i;
    mem_busy     = rst_ni & bus.mem_busy_i;
    fetch_open   = if_busy & ~if_ack;
    state_d      = state_q;
    latch_target = 1'b0;
    pc_we        = 1'b1;
    redirect     = 1'b0;
    drop         = 1'b0;
    stall        = 4'b0000;
    flush        = 4'b0000;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          pc_we    = 1'b0;
          stall    = 4'b0111;
          flush[3] = 1'b1;
        end else if (branch_req) begin
          flush = 4'b0011;
          if (fetch_open) begin
            pc_we        = 1'b0;
            latch_target = 1'b1;
            state_d      = REDIR_WAIT;
          end else begin
            redirect = 1'b1;
            drop     = if_ack;
          end
        end else if (hazard[0] || fetch_open) begin
          pc_we    = 1'b0;
          stall[0] = 1'b1;
          flush[1] = 1'b1;
        end
      end
      REDIR_WAIT: begin
        flush = 4'b0011;
        pc_we = if_ack;
        if (mem_busy) begin
          stall[2] = 1'b1;
          flush[3] = 1'b1;
        end
        if (if_ack) begin
          redirect = 1'b1;
          drop     = 1'b1;
          state_d  = RUN;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_we_o       = pc_we;
  assign bus.pc_redirect_o = redirect;
  assign bus.pc_target_o   = (state_q == REDIR_WAIT) ? target_q : bus.branch_target_i;
  assign bus.drop_fetch_o  = drop;
  assign bus.ifid_flush_o  = flush[0];
  assign bus.idex_flush_o  = flush[1];
  assign bus.exmem_flush_o = flush[2];
  assign bus.memwb_flush_o = flush[3];
  // A flushed register never also holds.
  assign bus.ifid_stall_o  = stall[0] & ~flush[0];
  assign bus.idex_stall_o  = stall[1] & ~flush[1];
  assign bus.exmem_stall_o = stall[2] & ~flush[2];
  assign bus.memwb_stall_o = stall[3] & ~flush[3];

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic        ifid_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt    <= 32'h0;
      flush_cnt    <= 32'h0;
      ifid_flush_q <= 1'b0;
    end else begin
      if (!pc_we && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'h1;
      if (flush[0] && !ifid_flush_q && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'h1;
      ifid_flush_q <= flush[0];
    end
  end

  assign bus.stall_cycles_o = stall_cnt;
  assign bus.flush_events_o = flush_cnt;
`else
  assign bus.stall_cycles_o = 32'h0;
  assign bus.flush_events_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// checked against a rule-based reference model.
module tb_pipeline_ctrl;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  pipeline_ctrl #(.ADDR_WIDTH(AW), .PC_ADDR(32'h8000_0000)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_we;
    logic       redirect;
    logic       drop;
    logic [3:0] stall;
    logic [3:0] flush;
    logic [31:0] target;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Reference model state: a redirect waiting on a fetch, its address, and the counter expectations.
  bit          mPending;
  logic [31:0] mTarget;
  logic [31:0] mStalls;
  logic [31:0] mFlushes;
  bit          mPrevFlush;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected response from the prioritized rules: pending redirect, memory busy, redirect request, load-use / fetch wait.
  function automatic exp_t predict(input logic [1:0] hz, input logic br, input logic [31:0] tgt,
                                   input logic busy, input logic ack, input logic mem, input bit inReset);
    exp_t e;
    bit pend;
    bit fetchOpen;
    if (inReset) begin
      hz = 2'b00; br = 1'b0; busy = 1'b0; ack = 1'b0; mem = 1'b0;
    end
    pend      = mPending && !inReset;
    fetchOpen = busy && !ack;
    e         = '0;
    e.pc_we   = 1'b1;
    e.target  = pend ? mTarget : tgt;
    if (pend) begin
      e.flush[3] = 1'b1; e.flush[2] = 1'b1;
      if (mem) begin e.stall[1] = 1'b1; e.flush[0] = 1'b1; end
      e.pc_we = ack; e.redirect = ack; e.drop = ack;
    end else if (mem) begin
      e.pc_we = 1'b0; e.stall[3] = 1'b1; e.stall[2] = 1'b1; e.stall[1] = 1'b1; e.flush[0] = 1'b1;
    end else if (br || hz[1]) begin
      e.flush[3] = 1'b1; e.flush[2] = 1'b1;
      if (fetchOpen) e.pc_we = 1'b0;
      else begin e.redirect = 1'b1; e.drop = ack; end
    end else if (hz[0] || fetchOpen) begin
      e.pc_we = 1'b0; e.stall[3] = 1'b1; e.flush[2] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [10:0] observedCtrl();
    return {bus.pc_we_o, bus.pc_redirect_o, bus.drop_fetch_o,
            bus.ifid_stall_o, bus.idex_stall_o, bus.exmem_stall_o, bus.memwb_stall_o,
            bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o};
  endfunction

  task automatic checkAll(input string tag, input exp_t e);
    logic [31:0] expStall;
    logic [31:0] expFlush;
    checkOutput({tag, "_ctrl"}, 32'(observedCtrl()), 32'({e.pc_we, e.redirect, e.drop, e.stall, e.flush}));
    checkOutput({tag, "_target"}, bus.pc_target_o, e.target);
`ifdef PIPE_PERF_CNT_EN
    expStall = mStalls;
    expFlush = mFlushes;
`else
    expStall = 32'h0;
    expFlush = 32'h0;
`endif
    checkOutput({tag, "_stallcnt"}, bus.stall_cycles_o, expStall);
    checkOutput({tag, "_flushcnt"}, bus.flush_events_o, expFlush);
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, advance the model at the rising edge.
  task automatic applyStimulus(input string tag, input logic [1:0] hz, input logic br, input logic [31:0] tgt,
                               input logic busy, input logic ack, input logic mem);
    exp_t e;
    @(negedge clk);
    bus.hazard_i        = hz;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    bus.if_busy_i       = busy;
    bus.if_ack_i        = ack;
    bus.mem_busy_i      = mem;
    #1;
    e = predict(hz, br, tgt, busy, ack, mem, 1'b0);
    checkAll(tag, e);
    @(posedge clk);
    if (mPending) begin
      if (ack) mPending = 1'b0;
    end else if (!mem && (br || hz[1]) && busy && !ack) begin
      mPending = 1'b1;
      mTarget  = tgt;
    end
    if (!e.pc_we && mStalls != 32'hFFFF_FFFF) mStalls = mStalls + 32'h1;
    if (e.flush[3] && !mPrevFlush && mFlushes != 32'hFFFF_FFFF) mFlushes = mFlushes + 32'h1;
    mPrevFlush = e.flush[3];
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset with arbitrary inputs, then release mid-cycle with idle inputs and no clock edge.
  task automatic doReset();
    exp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    tgt = $urandom;
    rst_n = 1'b0;
    bus.hazard_i        = 2'($urandom);
    bus.branch_taken_i  = 1'($urandom);
    bus.branch_target_i = tgt;
    bus.if_busy_i       = 1'($urandom);
    bus.if_ack_i        = 1'($urandom);
    bus.mem_busy_i      = 1'($urandom);
    mPending = 1'b0; mStalls = 32'h0; mFlushes = 32'h0; mPrevFlush = 1'b0;
    #1;
    e = predict(2'b00, 1'b0, tgt, 1'b0, 1'b0, 1'b0, 1'b1);
    checkAll("in_reset", e);
    bus.hazard_i = 2'b00; bus.branch_taken_i = 1'b0; bus.if_busy_i = 1'b0;
    bus.if_ack_i = 1'b0;  bus.mem_busy_i = 1'b0;     bus.branch_target_i = 32'h1234_5678;
    #1;
    rst_n = 1'b1;
    #1;
    e = predict(2'b00, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("post_reset", e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hazard_i = 2'b00; bus.branch_taken_i = 1'b0; bus.branch_target_i = 32'h0;
    bus.if_busy_i = 1'b0; bus.if_ack_i = 1'b0; bus.mem_busy_i = 1'b0;
    mPending = 1'b0; mTarget = 32'h0; mStalls = 32'h0; mFlushes = 32'h0; mPrevFlush = 1'b0;
    repeat (2) @(posedge clk);
    doReset();
    idle("idle");

    applyStimulus("loaduse", 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle("after_loaduse");

    applyStimulus("br_free", 2'b00, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b0);
    checkOutput("br_free_tgt_const", bus.pc_target_o, 32'h8000_0100);
    idle("after_br_free");

    applyStimulus("br_busy", 2'b00, 1'b1, 32'h8000_0200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("redir_wait", 2'($urandom), 1'($urandom), $urandom, 1'b1, 1'b0, 1'b0);
    applyStimulus("redir_ack", 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle("after_redir");

    for (int i = 0; i < 4; i++) applyStimulus("mem_busy", 2'b01, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 1'b1);
    applyStimulus("mem_release", 2'b01, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 1'b0);
    idle("after_mem");

    applyStimulus("redir_mem", 2'b00, 1'b1, 32'h8000_0400, 1'b1, 1'b0, 1'b0);
    applyStimulus("redir_mem_wait", 2'b00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    doReset();
    idle("after_abort");

    // Counter scenario from a clean reset: five load-use stalls and two separate branch flushes.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus("perf_stall", 2'b01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle("perf_gap0");
    applyStimulus("perf_br0", 2'b00, 1'b1, 32'h8000_0500, 1'b0, 1'b0, 1'b0);
    idle("perf_gap1");
    applyStimulus("perf_br1", 2'b10, 1'b0, 32'h8000_0600, 1'b0, 1'b0, 1'b0);
    idle("perf_gap2");
    #1;
`ifdef PIPE_PERF_CNT_EN
    checkOutput("perf_stall_total", bus.stall_cycles_o, 32'd5);
    checkOutput("perf_flush_total", bus.flush_events_o, 32'd2);
`else
    checkOutput("perf_stall_total", bus.stall_cycles_o, 32'd0);
    checkOutput("perf_flush_total", bus.flush_events_o, 32'd0);
`endif

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus("rand", 2'($urandom), ($urandom_range(0, 3) == 0), $urandom,
                    1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Consumer side of the hazard bus. Turns the hazard detector's stall/flush requests, the EX-stage branch resolution and the two Wishbone master busy flags into per-stage stall/flush enables and PC write/redirect controls.
- Sits between the hazard detector and the IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32 pipeline.
- Holds a pending redirect when a branch resolves while an instruction fetch is still in flight.

Parameters:
ADDR_WIDTH, 32, PC and branch target width
PC_ADDR, 32'h8000_0000, reset value of the latched redirect target

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, asynchronous, active-low
hazard_i  in  2  hazard detector bus; bit0 load-use stall request, bit1 flush request
branch_taken_i  in  1  branch/jump in EX resolved taken
branch_target_i  in  ADDR_WIDTH  redirect address from EX
if_busy_i  in  1  IF Wishbone master has an outstanding fetch
if_ack_i  in  1  IF fetch completes this cycle
mem_busy_i  in  1  MEM Wishbone master has an outstanding access
pc_we_o  out  1  PC register write enable
pc_redirect_o  out  1  PC takes pc_target_o instead of PC+4
pc_target_o  out  ADDR_WIDTH  redirect address
ifid_stall_o, idex_stall_o, exmem_stall_o, memwb_stall_o  out  1 each  hold stage register
ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1 each  load bubble (NOP) into stage register
drop_fetch_o  out  1  discard instruction returned by the completing fetch
stall_cycles_o  out  32  performance counter (see Optional Feature)
flush_events_o  out  32  performance counter (see Optional Feature)

Behaviour:
- States: RUN, REDIR_WAIT. Registered state plus target_q (ADDR_WIDTH).
- All outputs are combinational from state, target_q and inputs (zero latency).
- Reset (async, rst_ni=0): state=RUN, target_q=PC_ADDR, counters=0.
- During reset, outputs are evaluated as RUN with all inputs taken as 0: pc_we_o=1, every other control output 0, pc_target_o=branch_target_i.
- Stall and flush are never both 1 on the same register. Flush wins; the stall bit is forced to 0.
- Priority in RUN, highest first:
  - mem_busy_i=1: pc_we=0; stall IF/ID, ID/EX and EX/MEM; memwb_flush=1. Branch and hazard requests are ignored this cycle and re-evaluated once mem_busy_i drops.
  - branch_taken_i=1 or hazard_i[1]=1: ifid_flush=1, idex_flush=1.
    - if_busy_i=0 or if_ack_i=1: pc_we=1, pc_redirect=1, pc_target=branch_target_i. An acked fetch in the same cycle is dropped (drop_fetch=1).
    - if_busy_i=1 and if_ack_i=0: pc_we=0; latch target_q<=branch_target_i; next state REDIR_WAIT.
  - hazard_i[0]=1 (load-use): pc_we=0, ifid_stall=1, idex_flush=1.
  - if_busy_i=1 and if_ack_i=0: pc_we=0, ifid_stall=1, idex_flush=1.
  - Otherwise: pc_we=1, all stall/flush=0.
- REDIR_WAIT:
  - Every cycle: pc_we=0, ifid_flush=1, idex_flush=1; hazard_i and branch_taken_i ignored.
  - mem_busy_i also applies EX/MEM stall and MEM/WB flush as in RUN.
  - On if_ack_i=1: drop_fetch=1, pc_we=1, pc_redirect=1, pc_target=target_q, next state RUN.
- pc_target_o = target_q in REDIR_WAIT, branch_target_i otherwise.
- Async reset asserted in REDIR_WAIT aborts the pending redirect; the in-flight fetch result is not dropped (the IF master is reset as well).

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - stall_cycles_o increments every cycle with pc_we_o=0.
  - flush_events_o increments every cycle where ifid_flush_o rises (0→1 edge; registered previous value).
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: no counter registers; both ports are tied to 32'h0.

Test Plan:
- Reset, then idle inputs -> pc_we_o=1, all stall/flush=0, state RUN; release rst_ni mid-cycle with no clock -> outputs already valid.
- hazard_i=2'b01 for 1 cycle -> pc_we_o=0, ifid_stall_o=1, idex_flush_o=1 in that cycle only; next cycle back to normal.
- branch_taken_i=1, target 32'h8000_0100, if_busy_i=0 -> same cycle: pc_redirect_o=1, pc_target_o=32'h8000_0100, ifid_flush_o=idex_flush_o=1.
- branch_taken_i=1, target 32'h8000_0200, if_busy_i=1; if_ack_i=1 after 3 cycles -> 3 cycles in REDIR_WAIT with pc_we_o=0, flushes held; ack cycle: drop_fetch_o=1, pc_target_o=32'h8000_0200, pc_we_o=1.
- mem_busy_i=1 together with branch_taken_i=1 and hazard_i=2'b01 for 4 cycles -> exmem/idex/ifid stalled, memwb_flush_o=1, no redirect; cycle after mem_busy_i falls: redirect taken.
- With PIPE_PERF_CNT_EN: 5 stall cycles plus 2 branch flushes -> stall_cycles_o=5 (plus any REDIR_WAIT cycles), flush_events_o=2; without the macro -> both 0.
